dff_readback: RTL



---
 rtl/dff_readback_pkg.sv | 20 ++
 rtl/dff_readback_if.sv | 25 ++
 rtl/rb_shift_reg.sv | 28 ++
 rtl/dff_readback.sv | 135 +++++++++++++
 4 files changed

// File: rtl/dff_readback_pkg.sv
// Shared types and helpers for the flop readback unit.
// DFF_READBACK_PARITY_EN adds one even-parity beat per frame.
package dff_readback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } rb_state_e;

  // Beats per frame: data bits, plus the parity beat when enabled.
  function automatic int unsigned rb_beats(input int unsigned width);
`ifdef DFF_READBACK_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/dff_readback_if.sv
// Request, serial stream and status signals of the flop readback unit.
// The master side is the readback block, the slave side its controller.
interface dff_readback_if #(
  parameter int WIDTH = 8
);
  logic             snap_req;
  logic [WIDTH-1:0] state_in;
  logic             dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic             busy;
  logic             overrun;
  logic             ovr_clr;

  modport master (
    input  snap_req, state_in, dout_ready, ovr_clr,
    output dout, dout_valid, dout_last, busy, overrun
  );

  modport slave (
    output snap_req, state_in, dout_ready, ovr_clr,
    input  dout, dout_valid, dout_last, busy, overrun
  );
endinterface

// File: rtl/rb_shift_reg.sv
// Snapshot shadow register: parallel load, shift toward the LSB on enable.
// Only the LSB leaves the block; it is the bit currently on the wire.
module rb_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_val,
  output logic             lsb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= q >> 1;
    end
  end

  assign lsb = q[0];

endmodule

// File: rtl/dff_readback.sv
// Snapshots WIDTH flop outputs and streams them LSB-first on a valid/ready bit stream.
// DFF_READBACK_PARITY_EN appends an even-parity beat after the data beats.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | no frame; the only state in which snap_req captures
// ST_SHIFT | presenting shadow[0], data beat cnt of WIDTH
// ST_PAR   | presenting the latched parity bit as the final beat
module dff_readback
  import dff_readback_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  dff_readback_if.master bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BEATS = rb_beats(WIDTH);
  localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT_CNT = CNT_W'(BEATS - 1);

  rb_state_e        state;
  rb_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             shift_en;
  logic             valid;
  logic             xfer;
  logic             sh_lsb;
  logic             ovr_q;
  logic             par_bit;

  rb_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift_en(shift_en),
    .load_val(bus.state_in),
    .lsb     (sh_lsb)
  );

  assign valid = (state != ST_IDLE);
  assign xfer  = valid && bus.dout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.snap_req) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (xfer) begin
          shift_en = 1'b1;
          if (cnt == LAST_DATA_CNT) begin
`ifdef DFF_READBACK_PARITY_EN
            state_nxt = ST_PAR;
`else
            state_nxt = ST_IDLE;
`endif
          end
        end
      end
`ifdef DFF_READBACK_PARITY_EN
      ST_PAR: begin
        if (xfer) begin
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // cnt counts every accepted beat, so the parity beat is simply index WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (xfer) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef DFF_READBACK_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^bus.state_in;
    end
  end

  assign par_bit = (state == ST_PAR) && par_q;
`else
  assign par_bit = 1'b0;
`endif

  // A late request during any busy cycle is dropped but remembered; set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else if (bus.snap_req && valid) begin
      ovr_q <= 1'b1;
    end else if (bus.ovr_clr) begin
      ovr_q <= 1'b0;
    end
  end

  assign bus.dout       = ((state == ST_SHIFT) && sh_lsb) || par_bit;
  assign bus.dout_valid = valid;
  assign bus.dout_last  = valid && (cnt == LAST_BEAT_CNT);
  assign bus.busy       = valid;
  assign bus.overrun    = ovr_q;

endmodule
